// File: rtl/bht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_pkg
// Description : Shared types, constants and index function for the gshare BHT.
// Revision    : 1.0
// ============================================================================
package bht_pkg;

    typedef enum logic [0:0] {
        BHT_INIT = 1'b0,
        BHT_RUN  = 1'b1
    } bht_state_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t    BHT_CNT_INIT = 2'b01;
    localparam int unsigned BHT_PC_W     = 64;
    localparam int unsigned BHT_IDX_W    = 32;

    // PC slice above the instruction-alignment bits, low history bits XOR-folded in
    function automatic logic [BHT_IDX_W-1:0] bht_index(
        input logic [BHT_PC_W-1:0]  pc,
        input logic [BHT_IDX_W-1:0] hist,
        input int unsigned          ofs,
        input int unsigned          iw,
        input int unsigned          hist_bits
    );
        logic [BHT_IDX_W-1:0] base;
        logic [BHT_IDX_W-1:0] hmask;
        base  = BHT_IDX_W'((pc >> ofs) & ((64'd1 << iw) - 64'd1));
        hmask = (32'd1 << hist_bits) - 32'd1;
        return base ^ (hist & hmask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bht_sat_counter
// Description : Combinational 2-bit saturating counter next-value function.
// Revision    : 1.0
// ============================================================================
module bht_sat_counter
    import bht_pkg::*;
(
    input  bht_cnt_t i_cnt,
    input  logic     i_taken,
    output bht_cnt_t o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != 2'b11) begin
                o_cnt = i_cnt + 2'b01;
            end
        end else if (i_cnt != 2'b00) begin
            o_cnt = i_cnt - 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_bht.sv
`default_nettype none
// ============================================================================
// Module      : gshare_bht
// Description : Gshare branch history table with registered prediction,
//               non-speculative global history and an init sweep.
// Revision    : 1.0
// ============================================================================
module gshare_bht
    import bht_pkg::*;
#(
    parameter int unsigned VLEN       = 64,
    parameter bit          RVC        = 1'b1,
    parameter int unsigned NR_ENTRIES = 128,
    parameter int unsigned HIST_BITS  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_bp_i,
    input  logic                 debug_mode_i,
    output logic                 ready_o,
    input  logic                 lookup_valid_i,
    input  logic [VLEN-1:0]      lookup_pc_i,
    output logic                 pred_valid_o,
    output logic                 pred_taken_o,
    output logic [HIST_BITS-1:0] pred_hist_o,
    input  logic                 update_valid_i,
    input  logic [VLEN-1:0]      update_pc_i,
    input  logic [HIST_BITS-1:0] update_hist_i,
    input  logic                 update_taken_i
);

    localparam int unsigned c_idx_w = $clog2(NR_ENTRIES);
    localparam int unsigned c_ofs   = RVC ? 1 : 2;

    bht_state_e           r_state;
    bht_state_e           w_state_next;
    logic [c_idx_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   w_cnt_next;
    logic [HIST_BITS-1:0] r_ghr;
    logic [HIST_BITS-1:0] w_ghr_next;
    logic [HIST_BITS-1:0] w_ghr_shift;
    bht_cnt_t             r_table [NR_ENTRIES];
    logic                 w_run;
    logic                 w_upd_accept;
    logic [c_idx_w-1:0]   w_lookup_idx;
    logic [c_idx_w-1:0]   w_update_idx;
    bht_cnt_t             w_upd_new;
    logic                 r_pred_valid;
    logic                 r_pred_taken;
    logic [HIST_BITS-1:0] r_pred_hist;

    assign w_run        = (r_state == BHT_RUN);
    // A concurrent flush wins over the update
    assign w_upd_accept = update_valid_i && w_run && !debug_mode_i && !flush_bp_i;

    assign w_lookup_idx = c_idx_w'(bht_index(BHT_PC_W'(lookup_pc_i), BHT_IDX_W'(r_ghr),
                                             c_ofs, c_idx_w, HIST_BITS));
    assign w_update_idx = c_idx_w'(bht_index(BHT_PC_W'(update_pc_i), BHT_IDX_W'(update_hist_i),
                                             c_ofs, c_idx_w, HIST_BITS));

    bht_sat_counter u_sat_counter (
        .i_cnt   (r_table[w_update_idx]),
        .i_taken (update_taken_i),
        .o_cnt   (w_upd_new)
    );

    generate
        if (HIST_BITS == 1) begin : g_ghr_single
            assign w_ghr_shift = update_taken_i;
        end else begin : g_ghr_multi
            assign w_ghr_shift = {r_ghr[HIST_BITS-2:0], update_taken_i};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ghr_next   = r_ghr;
        case (r_state)
            BHT_INIT: begin
                if (flush_bp_i) begin
                    w_cnt_next = '0;
                    w_ghr_next = '0;
                end else begin
                    w_cnt_next = r_cnt + c_idx_w'(1);
                    if (r_cnt == c_idx_w'(NR_ENTRIES - 1)) begin
                        w_state_next = BHT_RUN;
                    end
                end
            end
            BHT_RUN: begin
                if (flush_bp_i) begin
                    w_state_next = BHT_INIT;
                    w_cnt_next   = '0;
                    w_ghr_next   = '0;
                end else if (w_upd_accept) begin
                    w_ghr_next = w_ghr_shift;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= BHT_INIT;
            r_cnt   <= '0;
            r_ghr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ghr   <= w_ghr_next;
        end
    end

    // Counter array is deliberately unreset; the sweep initialises it
    always_ff @(posedge clk_i) begin
        if (!w_run) begin
            r_table[r_cnt] <= BHT_CNT_INIT;
        end else if (w_upd_accept) begin
            r_table[w_update_idx] <= w_upd_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_hist  <= '0;
        end else begin
            r_pred_valid <= lookup_valid_i && w_run;
            r_pred_taken <= w_run && r_table[w_lookup_idx][1];
            r_pred_hist  <= r_ghr;
        end
    end

    assign ready_o      = w_run;
    assign pred_valid_o = r_pred_valid;
    assign pred_taken_o = r_pred_taken;
    assign pred_hist_o  = r_pred_hist;

endmodule
`default_nettype wire

// File: tb/tb_gshare_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_bht
// Description : Self-checking bench for gshare_bht with a behavioural model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gshare_bht;

    localparam int N = 128;

    logic        clk_i          = 1'b0;
    logic        rst_ni         = 1'b0;
    logic        flush_bp_i     = 1'b0;
    logic        debug_mode_i   = 1'b0;
    logic        ready_o;
    logic        lookup_valid_i = 1'b0;
    logic [63:0] lookup_pc_i    = 64'h0;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [2:0]  pred_hist_o;
    logic        update_valid_i = 1'b0;
    logic [63:0] update_pc_i    = 64'h0;
    logic [2:0]  update_hist_i  = 3'h0;
    logic        update_taken_i = 1'b0;

    always #5 clk_i = ~clk_i;

    gshare_bht #(
        .VLEN       (64),
        .RVC        (1'b1),
        .NR_ENTRIES (N),
        .HIST_BITS  (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_bp_i     (flush_bp_i),
        .debug_mode_i   (debug_mode_i),
        .ready_o        (ready_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_hist_o    (pred_hist_o),
        .update_valid_i (update_valid_i),
        .update_pc_i    (update_pc_i),
        .update_hist_i  (update_hist_i),
        .update_taken_i (update_taken_i)
    );

    int checks = 0;
    int errors = 0;

    // Model state: counters as plain integers, remaining init cycles, history
    int m_tbl [N];
    int m_init_left = N;
    int m_ghr       = 0;
    int exp_pv      = 0;
    int exp_pt      = 0;
    int exp_ph      = 0;
    int m_k;
    bit m_rdy;

    function automatic int idx_of(input logic [63:0] pc, input int hist);
        return int'((pc >> 1) & 64'd127) ^ (hist & 7);
    endfunction

    function automatic logic [63:0] pc_for(input int idx, input int hist);
        return 64'h8000_0000 | (64'((idx ^ hist) & 127) << 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_init_left = N;
            m_ghr       = 0;
            exp_pv      = 0;
            exp_pt      = 0;
            exp_ph      = 0;
        end else begin
            m_rdy  = (m_init_left == 0);
            exp_pv = (lookup_valid_i && m_rdy) ? 1 : 0;
            exp_pt = m_rdy ? ((m_tbl[idx_of(lookup_pc_i, m_ghr)] >= 2) ? 1 : 0) : 0;
            exp_ph = m_ghr;
            if (flush_bp_i) begin
                m_init_left = N;
                m_ghr       = 0;
            end else if (!m_rdy) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    foreach (m_tbl[i]) m_tbl[i] = 1;
                end
            end else if (update_valid_i && !debug_mode_i) begin
                m_k = idx_of(update_pc_i, int'(update_hist_i));
                if (update_taken_i) m_tbl[m_k] = (m_tbl[m_k] == 3) ? 3 : m_tbl[m_k] + 1;
                else                m_tbl[m_k] = (m_tbl[m_k] == 0) ? 0 : m_tbl[m_k] - 1;
                m_ghr = ((m_ghr << 1) | int'(update_taken_i)) & 7;
            end
        end
    end

    always @(negedge clk_i) begin
        chk("ready", int'(ready_o), (m_init_left == 0) ? 1 : 0);
        chk("pred_valid", int'(pred_valid_o), exp_pv);
        if (exp_pv != 0) begin
            chk("pred_taken", int'(pred_taken_o), exp_pt);
            chk("pred_hist", int'(pred_hist_o), exp_ph);
        end
    end

    task automatic upd(input logic [63:0] pc, input int hist, input logic taken);
        update_valid_i = 1'b1;
        update_pc_i    = pc;
        update_hist_i  = 3'(hist);
        update_taken_i = taken;
        @(negedge clk_i);
        update_valid_i = 1'b0;
    endtask

    task automatic look(input logic [63:0] pc, output int taken, output int hist);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        taken = int'(pred_taken_o);
        hist  = int'(pred_hist_o);
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (!ready_o && n < 1000) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, h;
        repeat (3) @(negedge clk_i);
        chk("reset_ready", int'(ready_o), 0);
        chk("reset_pred_valid", int'(pred_valid_o), 0);
        chk("reset_pred_hist", int'(pred_hist_o), 0);

        // Lookup held through the sweep: no valid predictions until RUN
        lookup_valid_i = 1'b1;
        lookup_pc_i    = 64'h8000_0010;
        rst_ni = 1'b1;
        count_init(n);
        chk("reset_sweep_len", n, 128);
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        chk("first_run_valid", int'(pred_valid_o), 1);
        chk("first_run_taken", int'(pred_taken_o), 0);

        // Saturation
        repeat (3) upd(64'h8000_0010, 0, 1'b1);
        look(64'h8000_001E, t, h);
        chk("sat_taken", t, 1);
        chk("sat_hist", h, 7);
        repeat (4) upd(64'h8000_0010, 0, 1'b0);
        look(64'h8000_0010, t, h);
        chk("sat_not_taken", t, 0);
        chk("sat_nt_hist", h, 0);
        upd(64'h8000_0010, 0, 1'b0);
        upd(64'h8000_0010, 0, 1'b1);
        look(64'h8000_0012, t, h);
        chk("sat_floor_then_t", t, 0);
        upd(64'h8000_0010, 0, 1'b1);
        look(64'h8000_0016, t, h);
        chk("sat_floor_then_tt", t, 1);

        // History aliasing: pc 0x80000040 with history 0 vs 5
        repeat (2) upd(64'h8000_0040, 0, 1'b1);
        repeat (3) upd(64'h8000_0100, 0, 1'b0);
        look(64'h8000_0040, t, h);
        chk("alias_h0_taken", t, 1);
        chk("alias_h0_hist", h, 0);
        upd(64'h8000_0100, 0, 1'b1);
        upd(64'h8000_0100, 0, 1'b0);
        upd(64'h8000_0100, 0, 1'b1);
        look(64'h8000_0040, t, h);
        chk("alias_h5_taken", t, 0);
        chk("alias_h5_hist", h, 5);

        // Same-index lookup/update collision on entry 20
        update_valid_i = 1'b1;
        update_pc_i    = pc_for(20, 0);
        update_hist_i  = 3'd0;
        update_taken_i = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc_for(20, 5);
        @(negedge clk_i);
        update_valid_i = 1'b0;
        lookup_valid_i = 1'b0;
        chk("collision_old", int'(pred_taken_o), 0);
        look(pc_for(20, 3), t, h);
        chk("collision_new", t, 1);
        chk("collision_hist", h, 3);

        // Debug mode drops updates
        debug_mode_i = 1'b1;
        repeat (2) upd(pc_for(50, 0), 0, 1'b1);
        debug_mode_i = 1'b0;
        look(pc_for(50, 3), t, h);
        chk("debug_taken", t, 0);
        chk("debug_hist", h, 3);

        // Flush with update, then flush again at sweep count 50
        flush_bp_i     = 1'b1;
        update_valid_i = 1'b1;
        update_pc_i    = pc_for(60, 0);
        update_hist_i  = 3'd0;
        update_taken_i = 1'b1;
        @(negedge clk_i);
        flush_bp_i     = 1'b0;
        update_valid_i = 1'b0;
        chk("flush_ready", int'(ready_o), 0);
        repeat (50) @(negedge clk_i);
        flush_bp_i = 1'b1;
        @(negedge clk_i);
        flush_bp_i = 1'b0;
        count_init(n);
        chk("flush_mid_sweep_len", n, 128);
        look(pc_for(60, 0), t, h);
        chk("flush_ghr_cleared", h, 0);
        chk("flush_update_dropped", t, 0);

        // Asynchronous reset mid-RUN
        repeat (2) upd(pc_for(70, 0), 0, 1'b1);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc_for(70, 3);
        @(negedge clk_i);
        chk("pre_reset_valid", int'(pred_valid_o), 1);
        chk("pre_reset_taken", int'(pred_taken_o), 1);
        chk("pre_reset_hist", int'(pred_hist_o), 3);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_ready", int'(ready_o), 0);
        chk("async_valid", int'(pred_valid_o), 0);
        chk("async_taken", int'(pred_taken_o), 0);
        chk("async_hist", int'(pred_hist_o), 0);
        lookup_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        count_init(n);
        chk("reset_again_sweep_len", n, 128);
        repeat (2) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
